sync_ena_scheduler: RTL and testbench

- Drives the `ena` transition-select bus of a synchronous circuit model; each clock cycle it fires at most one excited transition.
- Chooses among the currently excited transitions by round-robin or LFSR pseudo-random order, and supports free-run and single-step operation.
- Always meets the spec monitor's `ena` constraints: value in range, stable for the full cycle.
- Sits beside `circuit` in the bench; its `ena` feeds both `circuit` and the bound `spec` monitor.

---
 rtl/sync_sched_pkg.sv | 28 ++
 rtl/sync_ena_scheduler_pick.sv | 31 +++
 rtl/sync_ena_scheduler.sv | 137 +++++++++++++
 tb/tb_sync_ena_scheduler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sync_sched_pkg.sv
// Shared types and helpers for the ena scheduler.
// State encoding, mode codes and LFSR stepping.
package sync_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP_FIRE,
    STEP_HOLD
  } state_e;

  localparam logic MODE_RR   = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int idle_code(int ntrans);
    return ntrans + 1;
  endfunction

  function automatic logic [15:0] lfsr_adv(
    logic [15:0] v
  );
    return v[0] ? ((v >> 1) ^ LFSR_TAPS)
                : (v >> 1);
  endfunction

endpackage

// File: rtl/sync_ena_scheduler_pick.sv
// Rotating-priority first-set-bit search.
// Purely combinational; shared by RR and LFSR modes.
module rot_pri_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] start_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 valid_o
);

  localparam int IW = $clog2(N);

  always_comb begin
    int   j;
    logic found;
    j       = 0;
    found   = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < N; i++) begin
      j = int'(start_i) + i;
      if (j >= N) j = j - N;
      if (!found && req_i[j[IW-1:0]]) begin
        found = 1'b1;
        idx_o = IW'(j);
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/sync_ena_scheduler.sv
// Fires at most one excited transition per cycle
// on a registered ena bus (RR or LFSR order).
module sync_ena_scheduler
  import sync_sched_pkg::*;
#(
  parameter int          NTRANS   = 8,
  parameter int          EW       = $clog2(NTRANS + 2),
  parameter int          QUIESCE  = 16,
  parameter logic [15:0] SEED_RST = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              step_req,
  output logic              step_ack,
  input  logic              mode,
  input  logic              seed_load,
  input  logic [15:0]       seed,
  input  logic [NTRANS-1:0] excited,
  output logic [EW-1:0]     ena,
  output logic              fired,
  output logic              stall,
  output logic [31:0]       fire_count
);

  localparam int IW = $clog2(NTRANS);
  localparam int CW = $clog2(QUIESCE + 1);
  localparam logic [EW-1:0] IDLE_E =
    EW'(idle_code(NTRANS));

  state_e          state_q, state_d;
  logic [EW-1:0]   ena_q, ena_d;
  logic            fired_q, fired_d;
  logic            ack_q, ack_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     fc_q, fc_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [15:0]     lfsr_q, lfsr_d;

  logic [IW-1:0]   rr_start, lf_r, lf_start;
  logic [IW-1:0]   start, pidx;
  logic            pvalid, take;

  assign rr_start = (rr_q == IW'(NTRANS - 1))
                  ? '0 : rr_q + 1'b1;
  assign lf_r     = lfsr_q[IW-1:0];
  assign lf_start = (int'(lf_r) < NTRANS) ? lf_r
                  : IW'(int'(lf_r) - NTRANS);
  assign start    = (mode == MODE_LFSR)
                  ? lf_start : rr_start;

  rot_pri_pick #(
    .N(NTRANS)
  ) u_pick (
    .req_i  (excited),
    .start_i(start),
    .idx_o  (pidx),
    .valid_o(pvalid)
  );

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    ack_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (run)           state_d = RUN;
        else if (step_req) state_d = STEP_FIRE;
      end
      RUN: begin
        if (!run) state_d = IDLE;
        else      take    = pvalid;
      end
      STEP_FIRE: begin
        if (run) begin
          state_d = RUN;
        end else if (pvalid) begin
          take    = 1'b1;
          ack_d   = 1'b1;
          state_d = STEP_HOLD;
        end
      end
      STEP_HOLD: begin
        if (run)            state_d = RUN;
        else if (!step_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ena_d   = take ? EW'(pidx) : IDLE_E;
    fired_d = take;
    fc_d    = take ? fc_q + 32'd1 : fc_q;
    rr_d    = (take && mode == MODE_RR)
            ? pidx : rr_q;
    if (seed_load)
      lfsr_d = (seed == 16'h0) ? 16'h0001 : seed;
    else
      lfsr_d = lfsr_adv(lfsr_q);
    // idle cycles only count while actually running
    if (state_q == RUN && run && !pvalid)
      cnt_d = (cnt_q == CW'(QUIESCE))
            ? cnt_q : cnt_q + 1'b1;
    else
      cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ena_q   <= IDLE_E;
      fired_q <= 1'b0;
      ack_q   <= 1'b0;
      cnt_q   <= '0;
      fc_q    <= '0;
      rr_q    <= IW'(NTRANS - 1);
      lfsr_q  <= SEED_RST;
    end else begin
      state_q <= state_d;
      ena_q   <= ena_d;
      fired_q <= fired_d;
      ack_q   <= ack_d;
      cnt_q   <= cnt_d;
      fc_q    <= fc_d;
      rr_q    <= rr_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign ena        = ena_q;
  assign fired      = fired_q;
  assign step_ack   = ack_q;
  assign stall      = (cnt_q == CW'(QUIESCE));
  assign fire_count = fc_q;

endmodule

// File: tb/tb_sync_ena_scheduler.sv
// Directed vector table plus corner sequences
// and a randomized legality/stability run.
module tb_sync_ena_scheduler;
  import sync_sched_pkg::*;

  logic        clk = 1'b0;
  logic        reset, run, step_req, mode;
  logic        seed_load;
  logic [15:0] seed;
  logic [7:0]  excited;
  logic        step_ack, fired, stall;
  logic [3:0]  ena;
  logic [31:0] fire_count;

  int errors = 0;
  int checks = 0;
  bit mon_on = 1'b0;

  sync_ena_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .step_req  (step_req),
    .step_ack  (step_ack),
    .mode      (mode),
    .seed_load (seed_load),
    .seed      (seed),
    .excited   (excited),
    .ena       (ena),
    .fired     (fired),
    .stall     (stall),
    .fire_count(fire_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       run;
    logic       step;
    logic [7:0] exc;
    logic [3:0] ena;
    logic       fired;
    logic       ack;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(logic r, logic s,
    logic [7:0] x, logic [3:0] e,
    logic f, logic a);
    vec_t v;
    v.run = r; v.step = s; v.exc = x;
    v.ena = e; v.fired = f; v.ack = a;
    tv.push_back(v);
  endfunction

  task automatic run_table(input string tag);
    for (int i = 0; i < tv.size(); i++) begin
      run      = tv[i].run;
      step_req = tv[i].step;
      excited  = tv[i].exc;
      tick;
      chk($sformatf("%s%0d_ena", tag, i),
          32'(ena), 32'(tv[i].ena));
      chk($sformatf("%s%0d_fired", tag, i),
          32'(fired), 32'(tv[i].fired));
      chk($sformatf("%s%0d_ack", tag, i),
          32'(step_ack), 32'(tv[i].ack));
    end
    tv.delete();
  endtask

  // ena must be legal and constant across each cycle
  initial begin
    logic [3:0] a;
    forever begin
      @(posedge clk);
      #2 a = ena;
      @(negedge clk);
      if (mon_on) begin
        chk("ena_stable", 32'(ena), 32'(a));
        chk("ena_range",
            32'(ena <= 4'd9 && ena != 4'd8), 32'd1);
      end
    end
  end

  initial begin
    bit          seen[8];
    int          bad;
    int          nf;
    logic [31:0] fc0;
    logic [7:0]  prev;

    reset = 1'b1; run = 1'b1; step_req = 1'b0;
    mode = MODE_RR; seed_load = 1'b0;
    seed = 16'h0; excited = 8'hFF;
    tick;
    chk("rst_ena", 32'(ena), 32'd9);
    chk("rst_fired", 32'(fired), 32'd0);
    chk("rst_ack", 32'(step_ack), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fc", fire_count, 32'd0);
    reset = 1'b0;

    add(1, 0, 8'hFF, 9, 0, 0);
    for (int k = 0; k < 8; k++)
      add(1, 0, 8'hFF, 4'(k), 1, 0);
    add(1, 0, 8'hFF, 0, 1, 0);
    run_table("rr");
    chk("fc_after_rr", fire_count, 32'd9);

    add(1, 0, 8'h81, 7, 1, 0);
    add(1, 0, 8'h81, 0, 1, 0);
    add(1, 0, 8'h81, 7, 1, 0);
    add(1, 0, 8'h81, 0, 1, 0);
    add(1, 0, 8'h00, 9, 0, 0);
    run_table("fair");
    chk("stall_1", 32'(stall), 32'd0);
    for (int k = 0; k < 14; k++) tick;
    chk("stall_15", 32'(stall), 32'd0);
    tick;
    chk("stall_16", 32'(stall), 32'd1);
    chk("stall_ena", 32'(ena), 32'd9);
    tick;
    chk("stall_sat", 32'(stall), 32'd1);
    excited = 8'h01;
    tick;
    chk("stall_clr", 32'(stall), 32'd0);
    chk("stall_clr_ena", 32'(ena), 32'd0);

    add(0, 0, 8'h04, 9, 0, 0);
    add(0, 1, 8'h04, 9, 0, 0);
    add(0, 1, 8'h04, 2, 1, 1);
    add(0, 1, 8'h04, 9, 0, 0);
    add(0, 1, 8'h04, 9, 0, 0);
    add(0, 1, 8'h04, 9, 0, 0);
    add(0, 0, 8'h04, 9, 0, 0);
    add(0, 1, 8'h00, 9, 0, 0);
    add(0, 1, 8'h00, 9, 0, 0);
    add(0, 1, 8'h00, 9, 0, 0);
    add(0, 1, 8'h04, 2, 1, 1);
    add(0, 0, 8'h04, 9, 0, 0);
    add(0, 1, 8'h00, 9, 0, 0);
    add(1, 1, 8'h04, 9, 0, 0);
    add(1, 1, 8'h04, 2, 1, 0);
    add(0, 0, 8'h04, 9, 0, 0);
    run_table("step");
    chk("fc_after_step", fire_count, 32'd17);

    step_req = 1'b1; excited = 8'h00;
    tick;
    chk("sf_state", 32'(dut.state_q),
        32'(STEP_FIRE));
    reset = 1'b1;
    tick;
    chk("midrst_ena", 32'(ena), 32'd9);
    chk("midrst_ack", 32'(step_ack), 32'd0);
    chk("midrst_fired", 32'(fired), 32'd0);
    chk("midrst_fc", fire_count, 32'd0);
    chk("midrst_state", 32'(dut.state_q),
        32'(IDLE));
    reset = 1'b0; step_req = 1'b0;

    mode = MODE_LFSR; run = 1'b1;
    excited = 8'hFF;
    tick;
    seed_load = 1'b1; seed = 16'h0;
    tick;
    chk("seed0_lfsr", 32'(dut.lfsr_q), 32'h0001);
    seed_load = 1'b0;
    tick;
    chk("lfsr_pick1", 32'(ena), 32'd1);
    chk("lfsr_adv1", 32'(dut.lfsr_q), 32'hB400);
    tick;
    chk("lfsr_pick0", 32'(ena), 32'd0);
    chk("lfsr_adv2", 32'(dut.lfsr_q), 32'h5A00);
    bad = 0;
    for (int k = 0; k < 8; k++) seen[k] = 1'b0;
    for (int k = 0; k < 256; k++) begin
      tick;
      if (ena == 4'd8 || ena > 4'd9) bad++;
      else if (ena < 4'd8) seen[ena[2:0]] = 1'b1;
    end
    chk("lfsr_bad_codes", 32'(bad), 32'd0);
    for (int k = 0; k < 8; k++)
      chk($sformatf("lfsr_seen%0d", k),
          32'(seen[k]), 32'd1);

    fc0 = fire_count;
    nf  = 0;
    mon_on = 1'b1;
    for (int k = 0; k < 10000; k++) begin
      run       = ($urandom_range(0, 3) != 0);
      mode      = 1'($urandom_range(0, 1));
      step_req  = 1'($urandom_range(0, 1));
      seed_load = ($urandom_range(0, 63) == 0);
      seed      = 16'($urandom);
      excited   = ($urandom_range(0, 3) == 0)
                ? 8'h00 : 8'($urandom);
      prev = excited;
      tick;
      chk("rnd_fired_code", 32'(fired),
          32'(ena != 4'd9));
      if (fired) begin
        nf++;
        chk("rnd_fire_excited",
            32'((ena < 4'd8) ? prev[ena[2:0]]
                             : 1'b0), 32'd1);
      end
    end
    mon_on = 1'b0;
    chk("rnd_fire_count", fire_count - fc0,
        32'(nf));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
